// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the A/B encoder phases, decodes Gray-code
// transitions into up/down steps and keeps a loadable, wrapping position count.
module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             err_clr,
    output logic [WIDTH-1:0] qd,
    output logic             step,
    output logic             dir,
    output logic             err
);

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   sa;
    logic                   sb;
    logic                   pa;
    logic                   pb;
    logic                   up;
    logic                   down;
    logic                   illegal;

    // Synchronizers and previous-state register run through reset so that
    // stable inputs held across reset release decode as "no change".
    always_ff @(posedge clk) begin
        sync_a <= {sync_a[SYNC_STAGES-2:0], quad_a};
        sync_b <= {sync_b[SYNC_STAGES-2:0], quad_b};
        pa     <= sa;
        pb     <= sb;
    end

    assign sa = sync_a[SYNC_STAGES-1];
    assign sb = sync_b[SYNC_STAGES-1];

    always_comb begin
        up      = 1'b0;
        down    = 1'b0;
        illegal = 1'b0;
        case ({pa, pb, sa, sb})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: up      = 1'b1;
            4'b1000, 4'b1110, 4'b0111, 4'b0001: down    = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            qd   <= '0;
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
        end else begin
            // A load wins over a simultaneous decoded step, which is dropped.
            if (load) begin
                qd   <= d;
                step <= 1'b0;
            end else if (up) begin
                qd   <= qd + WIDTH'(1);
                step <= 1'b1;
                dir  <= 1'b1;
            end else if (down) begin
                qd   <= qd - WIDTH'(1);
                step <= 1'b1;
                dir  <= 1'b0;
            end else begin
                step <= 1'b0;
            end

            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus a random walk, all compared
// every cycle against a pin-history based reference model.
`timescale 1ns/1ps
module tb_quad_decoder;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         clear;
    logic         quad_a;
    logic         quad_b;
    logic         load;
    logic [W-1:0] d;
    logic         err_clr;
    logic [W-1:0] qd;
    logic         step;
    logic         dir;
    logic         err;

    int checks   = 0;
    int failures = 0;

    quad_decoder #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .clear   (clear),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .load    (load),
        .d       (d),
        .err_clr (err_clr),
        .qd      (qd),
        .step    (step),
        .dir     (dir),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the step decided at edge k is the transition between
    // the pin values sampled S+1 and S edges earlier.
    logic [1:0] hist[$];
    int         m_qd    = 0;
    int         m_step  = 0;
    int         m_dir   = 0;
    int         m_err   = 0;
    bit         m_valid = 0;

    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        int delta;
        hist.push_back({quad_a, quad_b});
        if (hist.size() > S + 2) void'(hist.pop_front());
        if (!clear) begin
            m_qd = 0; m_step = 0; m_dir = 0; m_err = 0; m_valid = 1;
        end else if (m_valid && hist.size() == S + 2) begin
            delta  = (phase(hist[1]) - phase(hist[0]) + 4) % 4;
            m_step = 0;
            if (delta == 2) m_err = 1;
            else if (err_clr) m_err = 0;
            if (load) m_qd = int'(d);
            else if (delta == 1) begin m_qd = (m_qd + 1) & MASK; m_step = 1; m_dir = 1; end
            else if (delta == 3) begin m_qd = (m_qd - 1) & MASK; m_step = 1; m_dir = 0; end
        end
    end

    int step_cnt = 0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_qd",   int'(qd),   m_qd);
            chk("model_step", int'(step), m_step);
            chk("model_dir",  int'(dir),  m_dir);
            chk("model_err",  int'(err),  m_err);
            if (step) step_cnt++;
        end
    end

    task automatic set_ab(input logic [1:0] ab, input int hold);
        @(negedge clk);
        {quad_a, quad_b} = ab;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic pulse_clear(input int cycles);
        @(negedge clk);
        clear = 1'b0;
        repeat (cycles) @(negedge clk);
        clear = 1'b1;
    endtask

    logic [1:0] fwd[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] cur;

    initial begin
        int s0;
        clear = 1'b0; quad_a = 1'b1; quad_b = 1'b1;
        load = 1'b0; d = '0; err_clr = 1'b0;

        // Reset with stable inputs, then release.
        repeat (4) @(negedge clk);
        clear = 1'b1;
        s0 = step_cnt;
        repeat (6) @(negedge clk);
        chk("reset_qd", int'(qd), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_no_step", step_cnt - s0, 0);

        // Re-reset while parked at 00 so forward counting starts at zero.
        {quad_a, quad_b} = 2'b00;
        pulse_clear(5);
        @(negedge clk);

        // Forward: 16 transitions; first one also pins the latency.
        s0 = step_cnt;
        @(negedge clk);
        {quad_a, quad_b} = 2'b10;
        repeat (S) @(negedge clk);
        chk("latency_before", int'(qd), 0);
        @(negedge clk);
        chk("latency_at", int'(qd), 1);
        repeat (2) @(negedge clk);
        for (int i = 1; i < 16; i++) set_ab(fwd[i % 4], 4);
        repeat (S + 1) @(negedge clk);
        chk("fwd_qd", int'(qd), 8'h10);
        chk("fwd_steps", step_cnt - s0, 16);
        chk("fwd_dir", int'(dir), 1);

        // Load 0x02 then reverse three transitions through the wrap.
        @(negedge clk); load = 1'b1; d = 8'h02;
        @(negedge clk); load = 1'b0;
        set_ab(2'b01, 4); chk("rev_1", int'(qd), 8'h01);
        set_ab(2'b11, 4); chk("rev_0", int'(qd), 8'h00);
        set_ab(2'b10, 4); chk("rev_wrap", int'(qd), 8'hFF);
        chk("rev_dir", int'(dir), 0);
        @(negedge clk); load = 1'b1; d = 8'hFF;
        @(negedge clk); load = 1'b0;
        set_ab(2'b11, 4); chk("fwd_wrap", int'(qd), 8'h00);

        // Illegal jump, sticky through legal steps, then clear.
        set_ab(2'b00, 4);
        chk("ill_qd", int'(qd), 8'h00);
        chk("ill_err", int'(err), 1);
        set_ab(2'b10, 4);
        set_ab(2'b11, 4);
        chk("ill_sticky", int'(err), 1);
        chk("ill_sticky_qd", int'(qd), 8'h02);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("errclr", int'(err), 0);

        // Illegal jump with err_clr held: the set wins on the decode edge.
        @(negedge clk); err_clr = 1'b1; {quad_a, quad_b} = 2'b00;
        repeat (S + 1) @(negedge clk);
        chk("set_wins", int'(err), 1);
        @(negedge clk); err_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Load lands on the same edge a forward step decodes.
        @(negedge clk); {quad_a, quad_b} = 2'b10;
        repeat (S) @(negedge clk);
        load = 1'b1; d = 8'h55;
        @(negedge clk); load = 1'b0;
        chk("ld_coll_qd", int'(qd), 8'h55);
        chk("ld_coll_step", int'(step), 0);
        repeat (2) @(negedge clk);
        set_ab(2'b11, 4);
        chk("ld_next", int'(qd), 8'h56);

        // Clear mid-rotation with err set.
        @(negedge clk); load = 1'b1; d = 8'h23;
        @(negedge clk); load = 1'b0;
        set_ab(2'b00, 4);
        chk("mid_pre_qd", int'(qd), 8'h23);
        chk("mid_pre_err", int'(err), 1);
        @(negedge clk); clear = 1'b0;
        @(negedge clk); clear = 1'b1;
        chk("mid_qd", int'(qd), 0);
        chk("mid_err", int'(err), 0);
        chk("mid_dir", int'(dir), 0);
        set_ab(2'b10, 4);
        set_ab(2'b11, 4);
        chk("mid_resume", int'(qd), 2);
        chk("mid_resume_err", int'(err), 0);

        // Random walk with occasional illegal jumps, loads, clears.
        cur = 2'b11;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                cur = ~cur;
                set_ab(cur, $urandom_range(1, 4));
            end else if (r == 1) begin
                @(negedge clk); load = 1'b1; d = W'($urandom);
                @(negedge clk); load = 1'b0;
            end else if (r == 2) begin
                @(negedge clk); err_clr = 1'b1;
                @(negedge clk); err_clr = 1'b0;
            end else if (r == 3) begin
                pulse_clear($urandom_range(1, 3));
            end else begin
                int p;
                p = phase(cur);
                p = ($urandom_range(0, 1) != 0) ? (p + 1) % 4 : (p + 3) % 4;
                cur = fwd[(p + 3) % 4];
                set_ab(cur, $urandom_range(1, 4));
            end
        end
        repeat (S + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder and position counter.
- Consumes the A/B phase pair from an incremental encoder, decodes each Gray-code transition into an up or down step, and keeps a loadable WIDTH-bit position count.
- Sits at the receive end of the encoder interface and replaces an externally driven up_down/count-enable pair.
- Flags illegal double-phase transitions.

Parameters:
- WIDTH, 8, width of position counter and load data.
- SYNC_STAGES, 2, synchronizer flops per phase input (min 2).

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  reset, synchronous, active-low
- quad_a  input  1  encoder phase A, asynchronous to clk
- quad_b  input  1  encoder phase B, asynchronous to clk
- load  input  1  load d into counter
- d  input  WIDTH  load value
- err_clr  input  1  clear sticky error flag
- qd  output  WIDTH  position count
- step  output  1  one-cycle pulse, counter stepped this cycle
- dir  output  1  direction of last accepted step (1 = up, 0 = down)
- err  output  1  sticky illegal-transition flag

Behaviour:
- Reset:
  - clk is the only clock.
  - clear is synchronous and active-low; it is sampled on rising clk only.
  - While clear = 0: qd = 0, step = 0, dir = 0, err = 0.
  - The synchronizer chains keep shifting during reset, and the previous-state register loads the synchronized AB every cycle. Stable inputs held through reset therefore produce no step and no err on release.
- Synchronization:
  - quad_a and quad_b each pass through SYNC_STAGES flops; the outputs are sa and sb.
  - The previous-state register {pa, pb} loads {sa, sb} every cycle.
- Decode ({pa,pb} -> {sa,sb}):
  - Up: 00->10, 10->11, 11->01, 01->00 (A leads B).
  - Down: the reverse of each up transition.
  - No change: no step.
  - Both bits changed (00<->11, 10<->01): illegal. No step; err set to 1.
- Counter update on each rising clk with clear = 1, in priority order:
  1. load = 1: qd <= d. step <= 0. dir unchanged. A concurrent decoded step is discarded. An illegal transition still sets err.
  2. Up step: qd <= qd + 1, wrapping 2^WIDTH-1 -> 0. step <= 1, dir <= 1.
  3. Down step: qd <= qd - 1, wrapping 0 -> 2^WIDTH-1. step <= 1, dir <= 0.
  4. Otherwise: qd holds, step <= 0.
- Arithmetic is modulo 2^WIDTH. There is no saturation and no overflow flag.
- err:
  - Sticky; set by any illegal transition.
  - Cleared by err_clr = 1 or clear = 0.
  - Set has priority over err_clr in the same cycle.
- Latency:
  - A phase change first sampled at rising edge N appears in sa/sb after edge N+SYNC_STAGES-1.
  - qd, step and dir update at edge N+SYNC_STAGES.
  - With the default this is 2 cycles after first sampling, 3 edges from the pin toggle.
- Throughput: one step per clk maximum. Encoder edges closer than one clk period are unsupported and appear as illegal transitions.
- No combinational path from any input to any output.

Test Plan:
- Hold clear = 0 for 4 cycles with A=B=1, then release with inputs stable -> qd = 0, step never asserts, err = 0.
- From qd = 0, drive 4 full forward cycles (AB 00,10,11,01,00 ...; 16 transitions, each held 4 clk) -> 16 single-cycle step pulses, dir = 1, final qd = 16 (0x10). Each qd change lands SYNC_STAGES edges after its pin change is first sampled.
- Load d = 0x02, then drive 3 reverse transitions -> qd goes 0x01, 0x00, 0xFF (wrap), dir = 0. Load d = 0xFF, then 1 forward transition -> qd = 0x00.
- Jump AB 00->11 in one clk -> qd unchanged, no step, err = 1 and stays 1 through subsequent legal steps. Pulse err_clr -> err = 0. Repeat the illegal jump while err_clr is held high -> err = 1 (set wins).
- Assert load with d = 0x55 in the same cycle a forward transition decodes -> qd = 0x55, step = 0, dir unchanged. The next forward transition gives qd = 0x56.
- Assert clear = 0 mid-rotation (qd = 0x23, err = 1) -> next edge qd = 0, err = 0, dir = 0. Continue rotating after release -> counting resumes from 0 with no spurious step or err.
